// File: rtl/rs_pkg.sv
// Shared types and constants for the adder reservation station.
// Tag 0 means "value present"; other tags name the slot producing a value.
package rs_pkg;

  localparam int TAG_W_DEF = 4;
  typedef logic [TAG_W_DEF-1:0] tag_t;
  localparam tag_t TAG_NONE = '0;

  localparam int OP_LSB = 0;
  localparam int OP_W   = 4;
  localparam int Y_LSB  = 4;
  localparam int X_LSB  = 7;
  localparam int RA_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1
  } adder_op_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder over a request vector.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downward means the last hit, the lowest index, wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_adder_station.sv
// Tomasulo reservation station for the adder: issue with renaming, CDB snoop,
// one-deep dispatch register to the adder, slot release on own-tag broadcast.
module rs_adder_station
  import rs_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int TAG_W     = 4,
  parameter int TAG_BASE  = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Adderin,
  input  logic [15:0]         instruction,
  output logic                IssueReady,
  output logic [2:0]          RegAddrJ,
  output logic [2:0]          RegAddrK,
  input  logic [DATA_W-1:0]   RegDataJ,
  input  logic [DATA_W-1:0]   RegDataK,
  input  logic                CdbValid,
  input  logic [TAG_W-1:0]    CdbTag,
  input  logic [DATA_W-1:0]   CdbData,
  output logic                ExecValid,
  input  logic                ExecReady,
  output logic [3:0]          ExecOp,
  output logic [DATA_W-1:0]   ExecA,
  output logic [DATA_W-1:0]   ExecB,
  output logic [TAG_W-1:0]    ExecTag,
  output logic [ENTRIES-1:0]  Busy
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int SRC_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

  function automatic logic [TAG_W-1:0] slot_tag(input int idx);
    return TAG_W'(TAG_BASE + idx);
  endfunction

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] disp_q, disp_d;
  logic [OP_W-1:0]    op_q [ENTRIES];
  logic [OP_W-1:0]    op_d [ENTRIES];
  logic [DATA_W-1:0]  vj_q [ENTRIES];
  logic [DATA_W-1:0]  vj_d [ENTRIES];
  logic [DATA_W-1:0]  vk_q [ENTRIES];
  logic [DATA_W-1:0]  vk_d [ENTRIES];
  logic [TAG_W-1:0]   qj_q [ENTRIES];
  logic [TAG_W-1:0]   qj_d [ENTRIES];
  logic [TAG_W-1:0]   qk_q [ENTRIES];
  logic [TAG_W-1:0]   qk_d [ENTRIES];
  logic [TAG_W-1:0]   stat_q [REG_COUNT];
  logic [TAG_W-1:0]   stat_d [REG_COUNT];

  logic               exec_valid_q, exec_valid_d;
  logic [OP_W-1:0]    exec_op_q, exec_op_d;
  logic [DATA_W-1:0]  exec_a_q, exec_a_d;
  logic [DATA_W-1:0]  exec_b_q, exec_b_d;
  logic [TAG_W-1:0]   exec_tag_q, exec_tag_d;

  logic [ENTRIES-1:0] free_req, ready_req;
  logic [IDX_W-1:0]   free_idx, ready_idx;
  logic               free_vld, ready_vld;
  logic               issue_go;

  logic [SRC_W-1:0]   src_j, src_k;
  logic [TAG_W-1:0]   st_j, st_k;
  logic [TAG_W-1:0]   res_qj, res_qk;
  logic [DATA_W-1:0]  res_vj, res_vk;
  logic [5:0]         unused_instr;

  assign unused_instr = instruction[15:10];
  assign RegAddrJ     = instruction[X_LSB +: RA_W];
  assign RegAddrK     = instruction[Y_LSB +: RA_W];
  assign src_j        = instruction[X_LSB +: SRC_W];
  assign src_k        = instruction[Y_LSB +: SRC_W];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      free_req[i]  = ~busy_q[i];
      ready_req[i] = busy_q[i] & ~disp_q[i] & (qj_q[i] == NO_TAG) & (qk_q[i] == NO_TAG);
    end
  end

  rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_req),
    .idx   (free_idx),
    .valid (free_vld)
  );

  rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
    .req   (ready_req),
    .idx   (ready_idx),
    .valid (ready_vld)
  );

  assign IssueReady = free_vld;
  assign issue_go   = Adderin & free_vld;

  // Source lookup uses the pre-rename status, so X==Y both see the old producer.
  always_comb begin
    st_j   = stat_q[src_j];
    st_k   = stat_q[src_k];
    res_qj = st_j;
    res_vj = '0;
    res_qk = st_k;
    res_vk = '0;
    if (st_j == NO_TAG) begin
      res_qj = NO_TAG;
      res_vj = RegDataJ;
    end else if (CdbValid && CdbTag == st_j) begin
      res_qj = NO_TAG;
      res_vj = CdbData;
    end
    if (st_k == NO_TAG) begin
      res_qk = NO_TAG;
      res_vk = RegDataK;
    end else if (CdbValid && CdbTag == st_k) begin
      res_qk = NO_TAG;
      res_vk = CdbData;
    end
  end

  always_comb begin
    busy_d       = busy_q;
    disp_d       = disp_q;
    op_d         = op_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    stat_d       = stat_q;
    exec_valid_d = exec_valid_q;
    exec_op_d    = exec_op_q;
    exec_a_d     = exec_a_q;
    exec_b_d     = exec_b_q;
    exec_tag_d   = exec_tag_q;

    if (!exec_valid_q || ExecReady) begin
      exec_valid_d = ready_vld;
      if (ready_vld) begin
        exec_op_d         = op_q[ready_idx];
        exec_a_d          = vj_q[ready_idx];
        exec_b_d          = vk_q[ready_idx];
        exec_tag_d        = slot_tag(int'(ready_idx));
        disp_d[ready_idx] = 1'b1;
      end
    end

    // Release is placed after dispatch so a slot freed this edge stays clear.
    if (CdbValid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i]) begin
          if (qj_q[i] != NO_TAG && qj_q[i] == CdbTag) begin
            qj_d[i] = NO_TAG;
            vj_d[i] = CdbData;
          end
          if (qk_q[i] != NO_TAG && qk_q[i] == CdbTag) begin
            qk_d[i] = NO_TAG;
            vk_d[i] = CdbData;
          end
          if (CdbTag == slot_tag(i)) begin
            busy_d[i] = 1'b0;
            disp_d[i] = 1'b0;
          end
        end
      end
      for (int r = 0; r < REG_COUNT; r++) begin
        if (stat_q[r] != NO_TAG && stat_q[r] == CdbTag) stat_d[r] = NO_TAG;
      end
    end

    if (issue_go) begin
      busy_d[free_idx] = 1'b1;
      disp_d[free_idx] = 1'b0;
      op_d[free_idx]   = instruction[OP_LSB +: OP_W];
      qj_d[free_idx]   = res_qj;
      vj_d[free_idx]   = res_vj;
      qk_d[free_idx]   = res_qk;
      vk_d[free_idx]   = res_vk;
      stat_d[src_j]    = slot_tag(int'(free_idx));
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q       <= '0;
      disp_q       <= '0;
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_a_q     <= '0;
      exec_b_q     <= '0;
      exec_tag_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
      for (int r = 0; r < REG_COUNT; r++) stat_q[r] <= '0;
    end else begin
      busy_q       <= busy_d;
      disp_q       <= disp_d;
      op_q         <= op_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      stat_q       <= stat_d;
      exec_valid_q <= exec_valid_d;
      exec_op_q    <= exec_op_d;
      exec_a_q     <= exec_a_d;
      exec_b_q     <= exec_b_d;
      exec_tag_q   <= exec_tag_d;
    end
  end

  assign Busy      = busy_q;
  assign ExecValid = exec_valid_q;
  assign ExecOp    = exec_op_q;
  assign ExecA     = exec_a_q;
  assign ExecB     = exec_b_q;
  assign ExecTag   = exec_tag_q;

endmodule
